// File: rtl/sample_extend_arbiter.sv
// ============================================================================
// Module   : sample_extend_arbiter
// Purpose  : Round-robin arbiter feeding one registered sign-extension stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sample_extend_arbiter #(
  parameter int NCHAN    = 4,
  parameter int CHAN_WID = 2,
  parameter int IN_WID   = 18,
  parameter int OUT_WID  = 24
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic [NCHAN-1:0]        req,
  input  logic [NCHAN*IN_WID-1:0] in_data,
  output logic [NCHAN-1:0]        ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WID-1:0]      out_data,
  output logic [CHAN_WID-1:0]     out_chan
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_VALID = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  localparam logic [CHAN_WID-1:0] c_LAST_INIT = CHAN_WID'(NCHAN - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CHAN_WID-1:0] r_last;
  logic [CHAN_WID-1:0] r_chan;
  logic [OUT_WID-1:0]  r_data;
  logic                r_valid;
  logic [NCHAN-1:0]    r_ack;

  logic                w_found;
  logic [CHAN_WID-1:0] w_sel;
  logic [IN_WID-1:0]   w_sample;
  logic [OUT_WID-1:0]  w_sext;
  logic [NCHAN-1:0]    w_chan_onehot;

  // Scan starts one past the last winner, so the previous grantee has lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 1; i <= NCHAN; i++) begin
      if (!w_found && req[(int'(r_last) + i) % NCHAN]) begin
        w_found = 1'b1;
        w_sel   = CHAN_WID'((int'(r_last) + i) % NCHAN);
      end
    end
  end

  assign w_sample      = in_data[int'(w_sel)*IN_WID +: IN_WID];
  assign w_sext        = {{(OUT_WID-IN_WID){w_sample[IN_WID-1]}}, w_sample};
  assign w_chan_onehot = NCHAN'(1) << r_chan;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_found)       w_state_nxt = S_VALID;
      S_VALID: if (out_ready)     w_state_nxt = S_ACK;
      S_ACK:   if (!req[r_chan])  w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_last  <= c_LAST_INIT;
      r_chan  <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ack   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_data  <= w_sext;
            r_chan  <= w_sel;
            r_last  <= w_sel;
            r_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_ack   <= w_chan_onehot;
          end
        end
        S_ACK: begin
          if (!req[r_chan]) begin
            r_ack <= '0;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_ack   <= '0;
        end
      endcase
    end
  end

  assign ack       = r_ack;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_chan  = r_chan;

endmodule

`default_nettype wire

// File: tb/tb_sample_extend_arbiter.sv
// ============================================================================
// Module   : tb_sample_extend_arbiter
// Purpose  : Scoreboard bench for sample_extend_arbiter (4 ch, 18 -> 24 bits).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sample_extend_arbiter;

  localparam int NCHAN    = 4;
  localparam int CHAN_WID = 2;
  localparam int IN_WID   = 18;
  localparam int OUT_WID  = 24;

  logic                    clk;
  logic                    rst_L;
  logic [NCHAN-1:0]        req;
  logic [NCHAN*IN_WID-1:0] in_data;
  logic [NCHAN-1:0]        ack;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_WID-1:0]      out_data;
  logic [CHAN_WID-1:0]     out_chan;

  int checks;
  int failures;
  int tb_last;
  logic [CHAN_WID+OUT_WID-1:0] exp_q[$];

  sample_extend_arbiter #(
    .NCHAN(NCHAN), .CHAN_WID(CHAN_WID), .IN_WID(IN_WID), .OUT_WID(OUT_WID)
  ) dut (
    .clk(clk), .rst_L(rst_L), .req(req), .in_data(in_data), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_WID-1:0] sext(input logic [IN_WID-1:0] s);
    logic signed [OUT_WID-1:0] v;
    v = $signed(s);
    return v;
  endfunction

  task automatic set_sample(input int k, input logic [IN_WID-1:0] v);
    in_data[k*IN_WID +: IN_WID] = v;
  endtask

  task automatic push_exp(input int k);
    logic [IN_WID-1:0] s;
    s = in_data[k*IN_WID +: IN_WID];
    exp_q.push_back({CHAN_WID'(k), sext(s)});
    tb_last = k;
  endtask

  // Scoreboard pop at the falling edge before an accepting rising edge, then advance.
  task automatic tick();
    logic [CHAN_WID+OUT_WID-1:0] e;
    @(negedge clk);
    if (rst_L && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got chan=%0d data=%h, none expected", out_chan, out_data);
      end else begin
        e = exp_q.pop_front();
        if ({out_chan, out_data} !== e) begin
          failures++;
          $display("FAIL sb_data: got chan=%0d data=%h, expected chan=%0d data=%h",
                   out_chan, out_data, e[OUT_WID +: CHAN_WID], e[OUT_WID-1:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_L = 1'b0;
    req = '1;
    out_ready = 1'b1;
    for (int k = 0; k < NCHAN; k++) set_sample(k, IN_WID'(18'h01000 + k));
    repeat (3) tick();
    checks++;
    if (ack !== 4'b0000 || out_valid !== 1'b0 || out_data !== 24'h0 || out_chan !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: ack=%b valid=%b data=%h chan=%0d, expected all zero",
               ack, out_valid, out_data, out_chan);
    end
    rst_L = 1'b1;
    push_exp(0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0) begin
      failures++;
      $display("FAIL reset_first_grant: valid=%b chan=%0d, expected valid=1 chan=0", out_valid, out_chan);
    end
    tick();
    checks++;
    if (ack !== 4'b0001 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack: ack=%b valid=%b, expected ack=0001 valid=0", ack, out_valid);
    end
    req = '0;
    tick();
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ack_release: ack=%b, expected 0000", ack);
    end
  endtask

  task automatic test_single();
    set_sample(2, 18'h20000);
    req = 4'b0100;
    out_ready = 1'b1;
    push_exp(2);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'hFE0000 || out_chan !== 2'd2) begin
      failures++;
      $display("FAIL single_out: valid=%b data=%h chan=%0d, expected 1 fe0000 2", out_valid, out_data, out_chan);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || ack !== 4'b0100) begin
      failures++;
      $display("FAIL single_ack: valid=%b ack=%b, expected 0 0100", out_valid, ack);
    end
    repeat (3) tick();
    checks++;
    if (ack !== 4'b0100) begin
      failures++;
      $display("FAIL single_ack_hold: ack=%b, expected 0100", ack);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL single_ack_drop: ack=%b, expected 0000", ack);
    end
  endtask

  task automatic test_fairness();
    int acks;
    logic [NCHAN-1:0] prev_ack;
    logic [NCHAN-1:0] nreq;
    for (int k = 0; k < NCHAN; k++) set_sample(k, IN_WID'(18'h2A000 + 18'h0111 * k));
    for (int g = 0; g < 8; g++) push_exp((tb_last + 1) % NCHAN);
    out_ready = 1'b1;
    req = '1;
    acks = 0;
    prev_ack = '0;
    for (int c = 0; c < 200 && acks < 8; c++) begin
      tick();
      checks++;
      if ($countones(ack) > 1 || (ack != '0 && out_valid)) begin
        failures++;
        $display("FAIL fair_ack_excl: ack=%b valid=%b, expected one-hot ack never with valid", ack, out_valid);
      end
      nreq = req;
      for (int k = 0; k < NCHAN; k++) begin
        if (ack[k]) nreq[k] = 1'b0;
        else if (!req[k]) nreq[k] = 1'b1;
      end
      if (ack != '0 && prev_ack == '0) acks++;
      prev_ack = ack;
      if (acks == 8) nreq = '0;
      req = nreq;
    end
    checks++;
    if (acks != 8) begin
      failures++;
      $display("FAIL fair_timeout: acks=%0d, expected 8", acks);
    end
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fair_drain: pending=%0d valid=%b, expected 0 0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    set_sample(1, 18'h1FFFF);
    out_ready = 1'b0;
    req = 4'b0010;
    push_exp(1);
    tick();
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      set_sample(1, IN_WID'($urandom));
      tick();
      if (out_valid !== 1'b1 || out_data !== 24'h01FFFF || out_chan !== 2'd1 || ack !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold: %0d bad cycles, last valid=%b data=%h chan=%0d ack=%b, expected 1 01ffff 1 0000",
               bad, out_valid, out_data, out_chan, ack);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0010 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release_ack: ack=%b valid=%b, expected 0010 0", ack, out_valid);
    end
    req = '0;
    tick();
  endtask

  task automatic test_violation();
    set_sample(1, 18'h3FFFF);
    out_ready = 1'b0;
    req = 4'b0010;
    push_exp(1);
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL viol_hold: valid=%b data=%h, expected 1 ffffff", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0010) begin
      failures++;
      $display("FAIL viol_ack: ack=%b, expected 0010", ack);
    end
    tick();
    checks++;
    if (ack !== 4'b0000) begin
      failures++;
      $display("FAIL viol_ack_one_cycle: ack=%b, expected 0000", ack);
    end
  endtask

  task automatic test_midreset();
    set_sample(3, 18'h12345);
    out_ready = 1'b0;
    req = 4'b1000;
    push_exp(3);
    tick();
    #2;
    rst_L = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || ack !== 4'b0000) begin
      failures++;
      $display("FAIL midrst_valid: valid=%b ack=%b, expected 0 0000", out_valid, ack);
    end
    exp_q.delete();
    tb_last = NCHAN - 1;
    req = '1;
    out_ready = 1'b1;
    for (int k = 0; k < NCHAN; k++) set_sample(k, IN_WID'(18'h30000 + k));
    tick();
    rst_L = 1'b1;
    push_exp(0);
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_chan !== 2'd0) begin
      failures++;
      $display("FAIL midrst_regrant: valid=%b chan=%0d, expected 1 0", out_valid, out_chan);
    end
    tick();
    #2;
    rst_L = 1'b0;
    #1;
    checks++;
    if (ack !== 4'b0000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_ack: ack=%b valid=%b, expected 0000 0", ack, out_valid);
    end
    req = '0;
    tick();
    rst_L = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    tb_last = NCHAN - 1;
    rst_L = 1'b0;
    req = '0;
    in_data = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_violation();
    test_midreset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: pending=%0d, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
